id_ex_issue: RTL and testbench

- ID/EX pipeline stage for the five-stage MIPS core; sits directly upstream of the ALU.
- Registers the decoded operation and operands from ID at each clock edge.
- Resolves RAW hazards by forwarding from the MEM and WB stages.
- Presents the final ALU `a`, `b` and 8-bit `op` combinationally from the registered state.
- Supports stall (hold) and flush (bubble insertion).

---
 rtl/id_ex_issue.sv | 184 ++++++++++++++++++
 tb/tb_id_ex_issue.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_issue.sv
`default_nettype none
// ============================================================================
//  Module   : id_ex_issue
//  Purpose  : ID/EX pipeline register for the five-stage MIPS core. Latches
//             the decoded operation and operands from ID, resolves RAW
//             hazards by forwarding from MEM and WB, and presents the final
//             ALU a/b/op combinationally from the registered state. Supports
//             stall (hold) and flush (bubble insertion).
//  Ports    :
//    clk, rst                 clock, asynchronous active-high reset
//    stall_e, flush_e         hold / bubble controls (flush wins)
//    op_d, rd1_d, rd2_d,      decoded op, register reads, immediate
//    imm_d
//    rs_d, rt_d, rd_d         register indices
//    alusrc_d, regdst_d,      b-operand select, destination select,
//    regwrite_d               write enable of the instruction
//    regwrite_m, writereg_m,  MEM-stage forwarding source
//    aluout_m
//    regwrite_w, writereg_w,  WB-stage forwarding source
//    result_w
//    op_e, a_e, b_e           ALU op and operands
//    writedata_e              forwarded rt value (store data)
//    writereg_e, regwrite_e   destination travelling with the instruction
//    valid_e                  E stage holds a real instruction
//    fwd_a_e, fwd_b_e         forward selects: 00 reg, 01 WB, 10 MEM
//  Revision : 1.0  initial release
// ============================================================================
module id_ex_issue #(
  parameter int          AW     = 5,
  parameter int          DW     = 32,
  parameter logic [7:0]  NOP_OP = 8'h00
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall_e,
  input  logic          flush_e,
  input  logic [7:0]    op_d,
  input  logic [DW-1:0] rd1_d,
  input  logic [DW-1:0] rd2_d,
  input  logic [DW-1:0] imm_d,
  input  logic [AW-1:0] rs_d,
  input  logic [AW-1:0] rt_d,
  input  logic [AW-1:0] rd_d,
  input  logic          alusrc_d,
  input  logic          regdst_d,
  input  logic          regwrite_d,
  input  logic          regwrite_m,
  input  logic [AW-1:0] writereg_m,
  input  logic [DW-1:0] aluout_m,
  input  logic          regwrite_w,
  input  logic [AW-1:0] writereg_w,
  input  logic [DW-1:0] result_w,
  output logic [7:0]    op_e,
  output logic [DW-1:0] a_e,
  output logic [DW-1:0] b_e,
  output logic [DW-1:0] writedata_e,
  output logic [AW-1:0] writereg_e,
  output logic          regwrite_e,
  output logic          valid_e,
  output logic [1:0]    fwd_a_e,
  output logic [1:0]    fwd_b_e
);

  localparam logic [1:0] c_FWD_REG = 2'b00;
  localparam logic [1:0] c_FWD_WB  = 2'b01;
  localparam logic [1:0] c_FWD_MEM = 2'b10;

  // --------------------------------------------------------------------------
  // E-stage state
  // --------------------------------------------------------------------------
  logic [7:0]    r_op;
  logic [DW-1:0] r_rd1;
  logic [DW-1:0] r_rd2;
  logic [DW-1:0] r_imm;
  logic [AW-1:0] r_rs;
  logic [AW-1:0] r_rt;
  logic [AW-1:0] r_writereg;
  logic          r_alusrc;
  logic          r_regwrite;
  logic          r_valid;

  // --------------------------------------------------------------------------
  // Forwarding
  // --------------------------------------------------------------------------
  logic          w_mem_hit_a;
  logic          w_mem_hit_b;
  logic          w_wb_hit_a;
  logic          w_wb_hit_b;
  logic [1:0]    w_fwd_a;
  logic [1:0]    w_fwd_b;
  logic [DW-1:0] w_src_a;
  logic [DW-1:0] w_src_b;

  // A write to register 0 is architecturally discarded, so it never matches.
  assign w_mem_hit_a = regwrite_m && (writereg_m != '0) && (writereg_m == r_rs);
  assign w_mem_hit_b = regwrite_m && (writereg_m != '0) && (writereg_m == r_rt);
  assign w_wb_hit_a  = regwrite_w && (writereg_w != '0) && (writereg_w == r_rs);
  assign w_wb_hit_b  = regwrite_w && (writereg_w != '0) && (writereg_w == r_rt);

  // MEM holds the younger result, so it takes priority over WB.
  always_comb begin
    w_fwd_a = c_FWD_REG;
    w_src_a = r_rd1;
    if (w_mem_hit_a) begin
      w_fwd_a = c_FWD_MEM;
      w_src_a = aluout_m;
    end else if (w_wb_hit_a) begin
      w_fwd_a = c_FWD_WB;
      w_src_a = result_w;
    end
  end

  always_comb begin
    w_fwd_b = c_FWD_REG;
    w_src_b = r_rd2;
    if (w_mem_hit_b) begin
      w_fwd_b = c_FWD_MEM;
      w_src_b = aluout_m;
    end else if (w_wb_hit_b) begin
      w_fwd_b = c_FWD_WB;
      w_src_b = result_w;
    end
  end

  // --------------------------------------------------------------------------
  // Stage register. Priority: flush > stall > load.
  // While stalled the operand registers capture the forwarded values, so a
  // producer that leaves WB during the stall is not lost once it is gone.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op       <= NOP_OP;
      r_rd1      <= '0;
      r_rd2      <= '0;
      r_imm      <= '0;
      r_rs       <= '0;
      r_rt       <= '0;
      r_writereg <= '0;
      r_alusrc   <= 1'b0;
      r_regwrite <= 1'b0;
      r_valid    <= 1'b0;
    end else if (flush_e) begin
      r_op       <= NOP_OP;
      r_rd1      <= '0;
      r_rd2      <= '0;
      r_imm      <= '0;
      r_rs       <= '0;
      r_rt       <= '0;
      r_writereg <= '0;
      r_alusrc   <= 1'b0;
      r_regwrite <= 1'b0;
      r_valid    <= 1'b0;
    end else if (stall_e) begin
      r_rd1      <= w_src_a;
      r_rd2      <= w_src_b;
    end else begin
      r_op       <= op_d;
      r_rd1      <= rd1_d;
      r_rd2      <= rd2_d;
      r_imm      <= imm_d;
      r_rs       <= rs_d;
      r_rt       <= rt_d;
      r_writereg <= regdst_d ? rd_d : rt_d;
      r_alusrc   <= alusrc_d;
      r_regwrite <= regwrite_d;
      r_valid    <= 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign op_e        = r_op;
  assign a_e         = w_src_a;
  assign b_e         = r_alusrc ? r_imm : w_src_b;
  assign writedata_e = w_src_b;
  assign writereg_e  = r_writereg;
  assign regwrite_e  = r_regwrite;
  assign valid_e     = r_valid;
  assign fwd_a_e     = w_fwd_a;
  assign fwd_b_e     = w_fwd_b;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_issue.sv
`default_nettype none
// ============================================================================
//  Module   : tb_id_ex_issue
//  Purpose  : Self-checking bench for id_ex_issue: table of directed vectors
//             plus hand-written reset and stall-retention sequences.
//  Revision : 1.0  initial release
// ============================================================================
module tb_id_ex_issue;

  localparam logic [7:0] c_EXE_ADD_OP = 8'h20;
  localparam logic [7:0] c_EXE_ORI_OP = 8'h0d;
  localparam logic [7:0] c_EXE_SUB_OP = 8'h22;
  localparam logic [7:0] c_EXE_AND_OP = 8'h24;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall_e, flush_e;
  logic [7:0]  op_d;
  logic [31:0] rd1_d, rd2_d, imm_d;
  logic [4:0]  rs_d, rt_d, rd_d;
  logic        alusrc_d, regdst_d, regwrite_d;
  logic        regwrite_m, regwrite_w;
  logic [4:0]  writereg_m, writereg_w;
  logic [31:0] aluout_m, result_w;
  logic [7:0]  op_e;
  logic [31:0] a_e, b_e, writedata_e;
  logic [4:0]  writereg_e;
  logic        regwrite_e, valid_e;
  logic [1:0]  fwd_a_e, fwd_b_e;

  int checks = 0;
  int errors = 0;

  id_ex_issue #(.AW(5), .DW(32), .NOP_OP(8'h00)) dut (
    .clk(clk), .rst(rst), .stall_e(stall_e), .flush_e(flush_e),
    .op_d(op_d), .rd1_d(rd1_d), .rd2_d(rd2_d), .imm_d(imm_d),
    .rs_d(rs_d), .rt_d(rt_d), .rd_d(rd_d),
    .alusrc_d(alusrc_d), .regdst_d(regdst_d), .regwrite_d(regwrite_d),
    .regwrite_m(regwrite_m), .writereg_m(writereg_m), .aluout_m(aluout_m),
    .regwrite_w(regwrite_w), .writereg_w(writereg_w), .result_w(result_w),
    .op_e(op_e), .a_e(a_e), .b_e(b_e), .writedata_e(writedata_e),
    .writereg_e(writereg_e), .regwrite_e(regwrite_e), .valid_e(valid_e),
    .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        stall, flush;
    logic [7:0]  op;
    logic [31:0] rd1, rd2, imm;
    logic [4:0]  rs, rt, rd;
    logic        alusrc, regdst, regwrite;
    logic        rwm;
    logic [4:0]  wrm;
    logic [31:0] alum;
    logic        rww;
    logic [4:0]  wrw;
    logic [31:0] resw;
    logic [7:0]  e_op;
    logic [31:0] e_a, e_b, e_wd;
    logic [4:0]  e_wr;
    logic        e_rw, e_v;
    logic [1:0]  e_fa, e_fb;
  } vec_t;

  localparam int NVEC = 11;
  vec_t vecs [NVEC];

  task automatic chk(input string tag, input string field,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s %s: got %h expected %h", tag, field, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [7:0] eop,
                         input logic [31:0] ea, input logic [31:0] eb,
                         input logic [31:0] ewd, input logic [4:0] ewr,
                         input logic erw, input logic ev,
                         input logic [1:0] efa, input logic [1:0] efb);
    chk(tag, "op_e",        {24'd0, op_e},       {24'd0, eop});
    chk(tag, "a_e",         a_e,                 ea);
    chk(tag, "b_e",         b_e,                 eb);
    chk(tag, "writedata_e", writedata_e,         ewd);
    chk(tag, "writereg_e",  {27'd0, writereg_e}, {27'd0, ewr});
    chk(tag, "regwrite_e",  {31'd0, regwrite_e}, {31'd0, erw});
    chk(tag, "valid_e",     {31'd0, valid_e},    {31'd0, ev});
    chk(tag, "fwd_a_e",     {30'd0, fwd_a_e},    {30'd0, efa});
    chk(tag, "fwd_b_e",     {30'd0, fwd_b_e},    {30'd0, efb});
  endtask

  task automatic drive_id(input logic st, input logic fl, input logic [7:0] op,
                          input logic [31:0] r1, input logic [31:0] r2,
                          input logic [31:0] im, input logic [4:0] rs,
                          input logic [4:0] rt, input logic [4:0] rd,
                          input logic asrc, input logic rdst, input logic rw);
    stall_e = st; flush_e = fl; op_d = op;
    rd1_d = r1; rd2_d = r2; imm_d = im;
    rs_d = rs; rt_d = rt; rd_d = rd;
    alusrc_d = asrc; regdst_d = rdst; regwrite_d = rw;
  endtask

  task automatic drive_mw(input logic rwm, input logic [4:0] wrm,
                          input logic [31:0] alum, input logic rww,
                          input logic [4:0] wrw, input logic [31:0] resw);
    regwrite_m = rwm; writereg_m = wrm; aluout_m = alum;
    regwrite_w = rww; writereg_w = wrw; result_w = resw;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // stall, flush, op, rd1, rd2, imm, rs, rt, rd, alusrc, regdst, regwrite,
    // rwm, wrm, alum, rww, wrw, resw,
    // e_op, e_a, e_b, e_wd, e_wr, e_rw, e_v, e_fa, e_fb
    vecs[0]  = '{1'b0, 1'b0, c_EXE_ADD_OP, 32'h5, 32'h7, 32'h0, 5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 1'b1,
                 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                 c_EXE_ADD_OP, 32'h5, 32'h7, 32'h7, 5'd3, 1'b1, 1'b1, 2'b00, 2'b00};
    vecs[1]  = '{1'b0, 1'b0, c_EXE_ADD_OP, 32'h1, 32'h2, 32'h0, 5'd8, 5'd8, 5'd9, 1'b0, 1'b1, 1'b1,
                 1'b1, 5'd8, 32'h11, 1'b1, 5'd8, 32'h22,
                 c_EXE_ADD_OP, 32'h11, 32'h11, 32'h11, 5'd9, 1'b1, 1'b1, 2'b10, 2'b10};
    vecs[2]  = '{1'b0, 1'b0, c_EXE_ADD_OP, 32'h1, 32'h2, 32'h0, 5'd8, 5'd8, 5'd9, 1'b0, 1'b1, 1'b1,
                 1'b0, 5'd8, 32'h11, 1'b1, 5'd8, 32'h22,
                 c_EXE_ADD_OP, 32'h22, 32'h22, 32'h22, 5'd9, 1'b1, 1'b1, 2'b01, 2'b01};
    vecs[3]  = '{1'b0, 1'b0, c_EXE_ADD_OP, 32'h1, 32'h2, 32'h0, 5'd0, 5'd0, 5'd9, 1'b0, 1'b1, 1'b1,
                 1'b1, 5'd0, 32'h11, 1'b1, 5'd0, 32'h22,
                 c_EXE_ADD_OP, 32'h1, 32'h2, 32'h2, 5'd9, 1'b1, 1'b1, 2'b00, 2'b00};
    vecs[4]  = '{1'b0, 1'b0, c_EXE_ORI_OP, 32'h3, 32'h4, 32'h0000FFFF, 5'd5, 5'd6, 5'd7, 1'b1, 1'b0, 1'b1,
                 1'b1, 5'd6, 32'hAA, 1'b0, 5'd0, 32'h0,
                 c_EXE_ORI_OP, 32'h3, 32'h0000FFFF, 32'hAA, 5'd6, 1'b1, 1'b1, 2'b00, 2'b10};
    vecs[5]  = '{1'b0, 1'b0, c_EXE_SUB_OP, 32'h10, 32'h20, 32'h5, 5'd7, 5'd3, 5'd1, 1'b0, 1'b1, 1'b0,
                 1'b1, 5'd3, 32'h33, 1'b1, 5'd7, 32'h77,
                 c_EXE_SUB_OP, 32'h77, 32'h33, 32'h33, 5'd1, 1'b0, 1'b1, 2'b01, 2'b10};
    vecs[6]  = '{1'b0, 1'b1, c_EXE_ADD_OP, 32'h5, 32'h6, 32'h7, 5'd3, 5'd4, 5'd5, 1'b1, 1'b1, 1'b1,
                 1'b1, 5'd0, 32'h55, 1'b1, 5'd0, 32'h66,
                 8'h00, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 2'b00, 2'b00};
    vecs[7]  = '{1'b0, 1'b0, c_EXE_ADD_OP, 32'h1, 32'h2, 32'h0, 5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 1'b1,
                 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                 c_EXE_ADD_OP, 32'h1, 32'h2, 32'h2, 5'd3, 1'b1, 1'b1, 2'b00, 2'b00};
    vecs[8]  = '{1'b1, 1'b1, c_EXE_SUB_OP, 32'h9, 32'h9, 32'h9, 5'd9, 5'd9, 5'd9, 1'b0, 1'b1, 1'b1,
                 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                 8'h00, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 2'b00, 2'b00};
    vecs[9]  = '{1'b0, 1'b0, c_EXE_AND_OP, 32'h44, 32'h55, 32'h0, 5'd10, 5'd11, 5'd12, 1'b0, 1'b0, 1'b1,
                 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                 c_EXE_AND_OP, 32'h44, 32'h55, 32'h55, 5'd11, 1'b1, 1'b1, 2'b00, 2'b00};
    vecs[10] = '{1'b1, 1'b0, 8'h30, 32'h1, 32'h1, 32'h0, 5'd1, 5'd1, 5'd1, 1'b1, 1'b1, 1'b0,
                 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                 c_EXE_AND_OP, 32'h44, 32'h55, 32'h55, 5'd11, 1'b1, 1'b1, 2'b00, 2'b00};

    drive_id(1'b0, 1'b0, 8'h00, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    drive_mw(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

    // Asynchronous reset between clock edges
    #2 rst = 1'b1;
    #1 chk_all("reset_async", 8'h00, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 2'b00, 2'b00);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;

    // Table-driven vectors
    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      drive_id(vecs[i].stall, vecs[i].flush, vecs[i].op, vecs[i].rd1, vecs[i].rd2,
               vecs[i].imm, vecs[i].rs, vecs[i].rt, vecs[i].rd,
               vecs[i].alusrc, vecs[i].regdst, vecs[i].regwrite);
      drive_mw(vecs[i].rwm, vecs[i].wrm, vecs[i].alum, vecs[i].rww, vecs[i].wrw, vecs[i].resw);
      @(posedge clk);
      #1 chk_all($sformatf("vec%0d", i), vecs[i].e_op, vecs[i].e_a, vecs[i].e_b,
                 vecs[i].e_wd, vecs[i].e_wr, vecs[i].e_rw, vecs[i].e_v,
                 vecs[i].e_fa, vecs[i].e_fb);
    end

    // Stall retention: WB value for rs retires during the stall
    @(negedge clk);
    drive_id(1'b0, 1'b0, c_EXE_ADD_OP, 32'h1, 32'h2, 32'h0, 5'd4, 5'd5, 5'd6, 1'b0, 1'b1, 1'b1);
    drive_mw(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    @(posedge clk);
    #1 chk("stall_load", "a_e", a_e, 32'h1);
    @(negedge clk);
    drive_id(1'b1, 1'b0, 8'h30, 32'hDEAD, 32'hBEEF, 32'h0, 5'd9, 5'd9, 5'd9, 1'b1, 1'b0, 1'b0);
    drive_mw(1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 32'h99);
    #1 chk("stall_wb", "a_e", a_e, 32'h99);
    chk("stall_wb", "fwd_a_e", {30'd0, fwd_a_e}, 32'h1);
    @(negedge clk);
    drive_mw(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    for (int k = 0; k < 2; k++) begin
      #1 chk_all($sformatf("stall_hold%0d", k), c_EXE_ADD_OP, 32'h99, 32'h2, 32'h2,
                 5'd6, 1'b1, 1'b1, 2'b00, 2'b00);
      @(negedge clk);
    end

    // Reset asserted mid-stall/flush, then first clean edge loads normally
    stall_e = 1'b1; flush_e = 1'b1;
    #2 rst = 1'b1;
    #1 chk_all("reset_mid", 8'h00, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 2'b00, 2'b00);
    @(negedge clk);
    rst = 1'b0;
    drive_id(1'b0, 1'b0, c_EXE_SUB_OP, 32'h8, 32'h9, 32'h0, 5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 1'b1);
    @(posedge clk);
    #1 chk_all("post_reset_load", c_EXE_SUB_OP, 32'h8, 32'h9, 32'h9, 5'd3, 1'b1, 1'b1, 2'b00, 2'b00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
